// File: rtl/recovery_rom.sv
// Debug-mode recovery ROM on the instruction-fetch bus, with episode tracking and runaway detection.
// Latency: LATENCY cycles from grant to rvalid_o, fully pipelined, one request per cycle.
// Backpressure: none, gnt_o follows req_i; optional hit counter enabled by RECOVERY_ROM_FETCH_CNT_EN.
module recovery_rom #(
   parameter logic [31:0] ROM_BASE  = 32'h00040080,
   parameter int          NUM_WORDS = 16,
   parameter int          LATENCY   = 1,
   parameter int          TIMEOUT   = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        recovery_active_o,
   output logic        recovery_timeout_o,
   output logic [15:0] fetch_count_o
);

   localparam int          CW       = $clog2(TIMEOUT) + 1;
   localparam logic [31:0] DRET_INS = 32'h7B200073;

   typedef enum logic {IDLE, ACTIVE} state_t;

   // Built-in recovery image: two nops, fence.i, dret, then ebreak padding.
   function automatic logic [31:0] image_word(input logic [7:0] idx);
      case (idx)
         8'd0, 8'd1: image_word = 32'h00000013;
         8'd2:       image_word = 32'h0000100F;
         8'd3:       image_word = DRET_INS;
         default:    image_word = 32'h00100073;
      endcase
   endfunction

   logic [31:0]        off;
   logic               hit;
   logic [31:0]        acc_dat;
   logic               entry;
   logic               dret_rsp;
   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] err_q;
   logic [31:0]        dat_q [LATENCY];
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               timeout_q;

   // The ROM never stalls; grant is forced low while reset is held.
   assign gnt_o   = req_i & rst_ni;

   // Address decode: word-aligned, at or above the base, inside the image.
   assign off     = addr_i - ROM_BASE;
   assign hit     = (addr_i >= ROM_BASE) && ((off >> 2) < 32'(NUM_WORDS)) && (addr_i[1:0] == 2'b00);
   assign acc_dat = hit ? image_word(off[9:2]) : 32'h0;

   // Response pipeline; data and error are zeroed in empty slots so outputs read 0 when idle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < LATENCY; i++) dat_q[i] <= 32'h0;
      end else begin
         vld_q[0] <= gnt_o;
         err_q[0] <= gnt_o & ~hit;
         dat_q[0] <= gnt_o ? acc_dat : 32'h0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign rvalid_o = vld_q[LATENCY-1];
   assign err_o    = err_q[LATENCY-1];
   assign rdata_o  = dat_q[LATENCY-1];

   // Episode starts on a fetch of the entry word and ends when dret comes back.
   assign entry    = gnt_o && (addr_i == ROM_BASE);
   assign dret_rsp = rvalid_o && !err_o && (rdata_o == DRET_INS);

   // Episode state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state: a re-entry beats a simultaneous dret return.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (entry) state_d = ACTIVE;
         ACTIVE:  if (entry) state_d = ACTIVE;
                  else if (dret_rsp) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Episode output decode.
   always_comb begin
      recovery_active_o = (state_q == ACTIVE);
   end

   // Episode fetch count: entry counts as fetch 1, saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (entry)
         cnt_d = CW'(1);
      else if (state_q == ACTIVE && dret_rsp)
         cnt_d = '0;
      else if (state_q == ACTIVE && gnt_o && cnt_q != '1)
         cnt_d = cnt_q + CW'(1);
   end

   // Count register and sticky runaway flag, raised as the TIMEOUT-th fetch is counted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_q | (cnt_d >= CW'(TIMEOUT));
      end
   end

   assign recovery_timeout_o = timeout_q;

`ifdef RECOVERY_ROM_FETCH_CNT_EN
   logic [15:0] fcnt_q;

   // Free-running count of granted hits since reset, wraps at 16 bits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          fcnt_q <= 16'h0;
      else if (gnt_o && hit) fcnt_q <= fcnt_q + 16'h1;
   end

   assign fetch_count_o = fcnt_q;
`else
   assign fetch_count_o = 16'h0;
`endif

endmodule
